// File: rtl/a25_copro15_pkg.sv
// rtl/a25_copro15_pkg.sv - CP15 register indices, operation codes and flush FSM encoding.
package a25_copro15_pkg;

  localparam logic [3:0] CRN_ID           = 4'd0;
  localparam logic [3:0] CRN_FLUSH        = 4'd1;
  localparam logic [3:0] CRN_CACHE_CTRL   = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE    = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE   = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE   = 4'd5;
  localparam logic [3:0] CRN_FAULT_STATUS = 4'd6;
  localparam logic [3:0] CRN_FAULT_ADDR   = 4'd7;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_MRC  = 2'd1;
  localparam logic [1:0] OP_MCR  = 2'd2;

  typedef enum logic {
    FLUSH_IDLE   = 1'b0,
    FLUSH_ACTIVE = 1'b1
  } flush_state_t;

endpackage

// File: rtl/a25_copro15_ctrl_if.sv
// rtl/a25_copro15_ctrl_if.sv - Core/cache facing signal bundle of the CP15 controller.
interface a25_copro15_ctrl_if #(
  parameter int AREA_BITS = 32
);
  logic                 i_core_stall;
  logic [3:0]           i_copro_crn;
  logic [1:0]           i_copro_operation;
  logic [31:0]          i_copro_write_data;
  logic                 i_fault;
  logic [7:0]           i_fault_status;
  logic [31:0]          i_fault_address;
  logic                 i_cache_flush_ack;
  logic [31:0]          o_copro_read_data;
  logic                 o_cache_enable;
  logic                 o_cache_flush_req;
  logic                 o_copro_busy;
  logic [AREA_BITS-1:0] o_cacheable_area;
  logic [AREA_BITS-1:0] o_updateable_area;
  logic [AREA_BITS-1:0] o_disruptive_area;
  logic                 o_fault_pending;

  modport master (
    output i_core_stall, i_copro_crn, i_copro_operation, i_copro_write_data,
    output i_fault, i_fault_status, i_fault_address, i_cache_flush_ack,
    input  o_copro_read_data, o_cache_enable, o_cache_flush_req, o_copro_busy,
    input  o_cacheable_area, o_updateable_area, o_disruptive_area, o_fault_pending
  );

  modport slave (
    input  i_core_stall, i_copro_crn, i_copro_operation, i_copro_write_data,
    input  i_fault, i_fault_status, i_fault_address, i_cache_flush_ack,
    output o_copro_read_data, o_cache_enable, o_cache_flush_req, o_copro_busy,
    output o_cacheable_area, o_updateable_area, o_disruptive_area, o_fault_pending
  );

endinterface

// File: rtl/a25_copro15_fault_fifo.sv
// rtl/a25_copro15_fault_fifo.sv - Fault record FIFO; a full FIFO still accepts a push paired with a pop.
module a25_copro15_fault_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 40,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_en   = i_pop && !o_empty;
    push_en  = i_push && (!o_full || pop_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is only ever read under a non-zero count, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/a25_copro15_ctrl.sv
// rtl/a25_copro15_ctrl.sv - CP15 system control: cache/region registers, flush handshake, fault log.
module a25_copro15_ctrl
  import a25_copro15_pkg::*;
#(
  parameter int          AREA_BITS   = 32,
  parameter int          FAULT_DEPTH = 4,
  parameter logic [31:0] ID_VALUE    = 32'h4156_0300
) (
  input  logic              i_clk,
  input  logic              i_rst,
  a25_copro15_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FAULT_DEPTH) + 1;

  logic [2:0]           cache_control_q, cache_control_d;
  logic [AREA_BITS-1:0] cacheable_q, cacheable_d;
  logic [AREA_BITS-1:0] updateable_q, updateable_d;
  logic [AREA_BITS-1:0] disruptive_q, disruptive_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          read_data_q, read_data_d;
  flush_state_t         state_q, state_d;

  logic                 is_mcr;
  logic                 is_mrc;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [39:0]          fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fault_drop;

  assign is_mcr    = !bus.i_core_stall && (bus.i_copro_operation == OP_MCR);
  assign is_mrc    = !bus.i_core_stall && (bus.i_copro_operation == OP_MRC);
  assign fifo_push = !bus.i_core_stall && bus.i_fault;
  assign fifo_pop  = is_mrc && (bus.i_copro_crn == CRN_FAULT_ADDR);
  // A full FIFO only loses the fault when no pop frees a slot this cycle.
  assign fault_drop = fifo_push && fifo_full && !fifo_pop;

  a25_copro15_fault_fifo #(
    .DEPTH (FAULT_DEPTH),
    .WIDTH (40)
  ) u_fault_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_data  ({bus.i_fault_status, bus.i_fault_address}),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    cache_control_d = cache_control_q;
    cacheable_d     = cacheable_q;
    updateable_d    = updateable_q;
    disruptive_d    = disruptive_q;
    overflow_d      = overflow_q;
    if (is_mcr) begin
      case (bus.i_copro_crn)
        CRN_CACHE_CTRL:   cache_control_d = bus.i_copro_write_data[2:0];
        CRN_CACHEABLE:    cacheable_d     = bus.i_copro_write_data[AREA_BITS-1:0];
        CRN_UPDATEABLE:   updateable_d    = bus.i_copro_write_data[AREA_BITS-1:0];
        CRN_DISRUPTIVE:   disruptive_d    = bus.i_copro_write_data[AREA_BITS-1:0];
        CRN_FAULT_STATUS: overflow_d      = 1'b0;
        default:          ;
      endcase
    end
    if (fault_drop) overflow_d = 1'b1;
  end

  always_comb begin
    read_data_d = read_data_q;
    if (!bus.i_core_stall) begin
      case (bus.i_copro_crn)
        CRN_ID:           read_data_d = ID_VALUE;
        CRN_CACHE_CTRL:   read_data_d = {29'd0, cache_control_q};
        CRN_CACHEABLE:    read_data_d = 32'(cacheable_q);
        CRN_UPDATEABLE:   read_data_d = 32'(updateable_q);
        CRN_DISRUPTIVE:   read_data_d = 32'(disruptive_q);
        CRN_FAULT_STATUS: read_data_d = {overflow_q, 7'd0, 8'(fifo_count), 8'd0, fifo_head[39:32]};
        CRN_FAULT_ADDR:   read_data_d = fifo_head[31:0];
        default:          read_data_d = 32'd0;
      endcase
    end
  end

  // The ack must end a flush even while the core is stalled on it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FLUSH_IDLE:   if (is_mcr && (bus.i_copro_crn == CRN_FLUSH)) state_d = FLUSH_ACTIVE;
      FLUSH_ACTIVE: if (bus.i_cache_flush_ack) state_d = FLUSH_IDLE;
      default:      state_d = FLUSH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cache_control_q <= '0;
      cacheable_q     <= '0;
      updateable_q    <= '0;
      disruptive_q    <= '0;
      overflow_q      <= 1'b0;
      read_data_q     <= '0;
      state_q         <= FLUSH_IDLE;
    end else begin
      cache_control_q <= cache_control_d;
      cacheable_q     <= cacheable_d;
      updateable_q    <= updateable_d;
      disruptive_q    <= disruptive_d;
      overflow_q      <= overflow_d;
      read_data_q     <= read_data_d;
      state_q         <= state_d;
    end
  end

  assign bus.o_copro_read_data = read_data_q;
  assign bus.o_cache_enable    = cache_control_q[0];
  assign bus.o_cache_flush_req = (state_q == FLUSH_ACTIVE);
  assign bus.o_copro_busy      = (state_q == FLUSH_ACTIVE);
  assign bus.o_cacheable_area  = cacheable_q;
  assign bus.o_updateable_area = updateable_q;
  assign bus.o_disruptive_area = disruptive_q;
  assign bus.o_fault_pending   = !fifo_empty;

endmodule

// File: tb/tb_a25_copro15_ctrl.sv
// tb/tb_a25_copro15_ctrl.sv - Directed bench for a25_copro15_ctrl with a read-data scoreboard and fault model.
module tb_a25_copro15_ctrl;
  import a25_copro15_pkg::*;

  localparam int AB    = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   flush_count = 0;
  logic prev_req = 1'b0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [39:0] fq[$];
  logic        ov = 1'b0;
  logic [31:0] last_exp = '0;

  a25_copro15_ctrl_if #(.AREA_BITS(AB)) bus ();

  a25_copro15_ctrl #(
    .AREA_BITS   (AB),
    .FAULT_DEPTH (DEPTH),
    .ID_VALUE    (32'h4156_0300)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_cache_flush_req && !prev_req) flush_count <= flush_count + 1;
    prev_req <= bus.o_cache_flush_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [7:0] hs;
    hs = (fq.size() != 0) ? fq[0][39:32] : 8'd0;
    return {ov, 7'd0, 8'(fq.size()), 8'd0, hs};
  endfunction

  function automatic logic [31:0] exp_head_addr();
    return (fq.size() != 0) ? fq[0][31:0] : 32'd0;
  endfunction

  task automatic mcr(input logic [3:0] crn, input logic [31:0] data);
    bus.i_copro_operation  = OP_MCR;
    bus.i_copro_crn        = crn;
    bus.i_copro_write_data = data;
    if (crn == CRN_FAULT_STATUS) ov = 1'b0;
    step();
    bus.i_copro_operation = OP_NONE;
  endtask

  task automatic mrc(input logic [3:0] crn, input logic [31:0] exp, input string tag);
    bus.i_copro_operation = OP_MRC;
    bus.i_copro_crn       = crn;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    last_exp = exp;
    step();
    bus.i_copro_operation = OP_NONE;
    check(tag_q.pop_front(), bus.o_copro_read_data, exp_q.pop_front());
  endtask

  task automatic mrc_pop(input string tag);
    mrc(CRN_FAULT_ADDR, exp_head_addr(), tag);
    if (fq.size() != 0) void'(fq.pop_front());
  endtask

  task automatic fault(input logic [7:0] st, input logic [31:0] addr);
    bus.i_fault         = 1'b1;
    bus.i_fault_status  = st;
    bus.i_fault_address = addr;
    if (fq.size() < DEPTH) fq.push_back({st, addr});
    else ov = 1'b1;
    step();
    bus.i_fault = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_core_stall       = 1'b0;
    bus.i_copro_crn        = 4'd0;
    bus.i_copro_operation  = OP_NONE;
    bus.i_copro_write_data = '0;
    bus.i_fault            = 1'b0;
    bus.i_fault_status     = '0;
    bus.i_fault_address    = '0;
    bus.i_cache_flush_ack  = 1'b0;
    step();
    step();
    check("rst_rdata", bus.o_copro_read_data, 32'd0);
    check("rst_busy", {31'd0, bus.o_copro_busy}, 32'd0);
    check("rst_req", {31'd0, bus.o_cache_flush_req}, 32'd0);
    check("rst_cacheable", 32'(bus.o_cacheable_area), 32'd0);
    check("rst_updateable", 32'(bus.o_updateable_area), 32'd0);
    check("rst_disruptive", 32'(bus.o_disruptive_area), 32'd0);
    check("rst_pending", {31'd0, bus.o_fault_pending}, 32'd0);
    rst = 1'b0;

    mrc(CRN_ID, 32'h4156_0300, "id_read");

    mcr(CRN_CACHEABLE, 32'hFFFF_0001);
    check("cacheable_out", 32'(bus.o_cacheable_area), 32'h0000_0001);
    mrc(CRN_CACHEABLE, 32'h0000_0001, "cacheable_read");
    mcr(CRN_UPDATEABLE, 32'h1234_ABCD);
    check("updateable_out", 32'(bus.o_updateable_area), 32'h0000_ABCD);
    mrc(CRN_UPDATEABLE, 32'h0000_ABCD, "updateable_read");
    mcr(CRN_DISRUPTIVE, 32'h0000_5A5A);
    mrc(CRN_DISRUPTIVE, 32'h0000_5A5A, "disruptive_read");
    mcr(CRN_CACHE_CTRL, 32'hFFFF_FFF5);
    check("cache_enable", {31'd0, bus.o_cache_enable}, 32'd1);
    mrc(CRN_CACHE_CTRL, 32'd5, "cache_ctrl_read");
    mrc(4'd9, 32'd0, "unmapped_read");
    mrc(CRN_FLUSH, 32'd0, "crn1_read");

    mcr(CRN_FLUSH, 32'd0);
    check("flush_req_on", {31'd0, bus.o_cache_flush_req}, 32'd1);
    check("busy_on", {31'd0, bus.o_copro_busy}, 32'd1);
    mcr(CRN_FLUSH, 32'd0);
    step();
    step();
    step();
    check("busy_held", {31'd0, bus.o_copro_busy}, 32'd1);
    bus.i_cache_flush_ack = 1'b1;
    step();
    bus.i_cache_flush_ack = 1'b0;
    check("flush_req_off", {31'd0, bus.o_cache_flush_req}, 32'd0);
    check("busy_off", {31'd0, bus.o_copro_busy}, 32'd0);
    step();
    step();
    step();
    check("no_queued_flush", {31'd0, bus.o_cache_flush_req}, 32'd0);
    check("flush_once", 32'(flush_count), 32'd1);
    bus.i_cache_flush_ack = 1'b1;
    step();
    bus.i_cache_flush_ack = 1'b0;
    check("idle_ack_ignored", {31'd0, bus.o_copro_busy}, 32'd0);

    bus.i_core_stall = 1'b1;
    mcr(CRN_FLUSH, 32'd0);
    bus.i_core_stall = 1'b0;
    check("stalled_flush_ignored", {31'd0, bus.o_copro_busy}, 32'd0);
    mcr(CRN_FLUSH, 32'd0);
    bus.i_core_stall      = 1'b1;
    bus.i_cache_flush_ack = 1'b1;
    step();
    bus.i_core_stall      = 1'b0;
    bus.i_cache_flush_ack = 1'b0;
    check("ack_under_stall", {31'd0, bus.o_copro_busy}, 32'd0);

    for (int i = 1; i <= 5; i++) fault(8'(8'h10 + i), 32'(i * 32'h100));
    check("fifo_full_pending", {31'd0, bus.o_fault_pending}, 32'd1);
    mrc(CRN_FAULT_STATUS, 32'h8004_0011, "overflow_status");
    for (int i = 1; i <= 4; i++) mrc_pop($sformatf("pop_%0d", i));
    check("drained_pending", {31'd0, bus.o_fault_pending}, 32'd0);
    mrc_pop("pop_empty");
    mrc(CRN_FAULT_STATUS, exp_status(), "empty_status_sticky");
    mcr(CRN_FAULT_STATUS, 32'hFFFF_FFFF);
    mrc(CRN_FAULT_STATUS, exp_status(), "overflow_cleared");

    for (int i = 1; i <= 4; i++) fault(8'(8'h20 + i), 32'hA00 + 32'(i));
    bus.i_fault           = 1'b1;
    bus.i_fault_status    = 8'h25;
    bus.i_fault_address   = 32'hA05;
    bus.i_copro_operation = OP_MRC;
    bus.i_copro_crn       = CRN_FAULT_ADDR;
    exp_q.push_back(exp_head_addr());
    tag_q.push_back("full_push_pop_data");
    void'(fq.pop_front());
    fq.push_back({8'h25, 32'hA05});
    step();
    bus.i_fault           = 1'b0;
    bus.i_copro_operation = OP_NONE;
    check(tag_q.pop_front(), bus.o_copro_read_data, exp_q.pop_front());
    mrc(CRN_FAULT_STATUS, exp_status(), "full_push_pop_status");
    fault(8'h26, 32'hA06);
    bus.i_fault         = 1'b1;
    bus.i_fault_status  = 8'h27;
    bus.i_fault_address = 32'hA07;
    mcr(CRN_FAULT_STATUS, 32'd0);
    bus.i_fault = 1'b0;
    ov = 1'b1;
    mrc(CRN_FAULT_STATUS, exp_status(), "drop_beats_clear");
    mcr(CRN_FAULT_STATUS, 32'd0);
    mrc(CRN_FAULT_STATUS, exp_status(), "clear_after_drop");

    bus.i_core_stall = 1'b1;
    mcr(CRN_CACHE_CTRL, 32'd0);
    bus.i_fault         = 1'b1;
    bus.i_fault_status  = 8'h99;
    bus.i_fault_address = 32'hDEAD;
    step();
    bus.i_fault           = 1'b0;
    bus.i_copro_operation = OP_MRC;
    bus.i_copro_crn       = CRN_FAULT_ADDR;
    step();
    bus.i_copro_operation = OP_NONE;
    check("stall_rdata_hold", bus.o_copro_read_data, last_exp);
    check("stall_enable_hold", {31'd0, bus.o_cache_enable}, 32'd1);
    bus.i_core_stall = 1'b0;
    mrc(CRN_CACHE_CTRL, 32'd5, "stall_ctrl_unchanged");
    mrc(CRN_FAULT_STATUS, exp_status(), "stall_fifo_unchanged");

    mcr(CRN_FLUSH, 32'd0);
    check("pre_reset_busy", {31'd0, bus.o_copro_busy}, 32'd1);
    rst = 1'b1;
    step();
    check("reset_abort_busy", {31'd0, bus.o_copro_busy}, 32'd0);
    check("reset_rdata", bus.o_copro_read_data, 32'd0);
    check("reset_cacheable", 32'(bus.o_cacheable_area), 32'd0);
    check("reset_pending", {31'd0, bus.o_fault_pending}, 32'd0);
    rst = 1'b0;
    fq.delete();
    ov = 1'b0;
    bus.i_cache_flush_ack = 1'b1;
    step();
    bus.i_cache_flush_ack = 1'b0;
    check("late_ack_ignored", {31'd0, bus.o_cache_flush_req}, 32'd0);
    mrc(CRN_FAULT_STATUS, exp_status(), "reset_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a25_copro15_ctrl.md
A25_COPRO15_CTRL -- requirements
Module: a25_copro15_ctrl

Interface
REQ-001 Parameter AREA_BITS, default 32: width of the cacheable, updateable and disruptive region masks; each bit covers 2MB, range 1..32.
REQ-002 Parameter FAULT_DEPTH, default 4: fault FIFO entries; power of 2, range 2..16.
REQ-003 Parameter ID_VALUE, default 32'h4156_0300: value returned from CRn 0.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Ports, in order:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_core_stall  in  1  freezes all register, FIFO and read-data updates.
- i_copro_crn  in  4  register number.
- i_copro_operation  in  2  1 = MRC read, 2 = MCR write, other values = none.
- i_copro_write_data  in  32  MCR data.
- i_fault  in  1  fault capture strobe.
- i_fault_status  in  8  fault status.
- i_fault_address  in  32  fault address.
- i_cache_flush_ack  in  1  cache has completed the flush.
- o_copro_read_data  out  32  registered read data.
- o_cache_enable  out  1  cache enable.
- o_cache_flush_req  out  1  flush request, level signal.
- o_copro_busy  out  1  core must stall while high.
- o_cacheable_area  out  AREA_BITS  cacheable mask.
- o_updateable_area  out  AREA_BITS  updateable mask.
- o_disruptive_area  out  AREA_BITS  disruptive mask.
- o_fault_pending  out  1  fault FIFO is not empty.

Function
REQ-006 Register file: an MCR to CRn 2 loads cache_control from write_data[2:0]; CRn 3, 4 and 5 load the cacheable, updateable and disruptive masks from write_data[AREA_BITS-1:0]. All writes are gated by !i_core_stall.
REQ-007 Read path: every unstalled cycle, o_copro_read_data registers the value selected by the current i_copro_crn (1-cycle latency, independent of operation).
- CRn 0: ID_VALUE.
- CRn 2: {29'd0, cache_control}.
- CRn 3-5: the masks, zero-extended.
- CRn 6: {overflow, 7'd0, count (zero-extended to 8 bits), 8'd0, head_status}.
- CRn 7: head_address.
- Other CRn: 0. When the FIFO is empty, head fields read 0.
REQ-008 o_cache_enable SHALL equal cache_control[0].
REQ-009 Flush FSM, IDLE -> FLUSH: taken on an unstalled MCR to CRn 1.
REQ-010 Flush FSM, in FLUSH: o_cache_flush_req = 1 and o_copro_busy = 1.
REQ-011 Flush FSM, FLUSH -> IDLE: taken on the first cycle i_cache_flush_ack = 1, regardless of i_core_stall. Both outputs are 0 in IDLE.
REQ-012 An MCR to CRn 1 while in FLUSH SHALL be ignored; there is no queuing.
REQ-013 An ack while in IDLE SHALL be ignored.
REQ-014 Fault FIFO push: an unstalled i_fault pushes {status, address}.
REQ-015 Fault FIFO pop: an unstalled MRC to CRn 7 with the FIFO not empty pops the head. Read data registered in the same cycle holds the pre-pop head.
REQ-016 Push and pop in the same cycle: both take effect and count is unchanged, including when the FIFO is full.
REQ-017 Push when full without a pop: the new fault is dropped and sticky overflow is set.
REQ-018 Pop when empty: no effect.
REQ-019 Overflow clear: an MCR to CRn 6 clears overflow, whatever the write data. If a drop occurs in the same cycle, set wins.
REQ-020 Pointer arithmetic: pointers are log2(FAULT_DEPTH) bits and wrap modulo FAULT_DEPTH; count is log2(FAULT_DEPTH)+1 bits, range 0..FAULT_DEPTH.
REQ-021 o_fault_pending SHALL equal (count != 0).

Reset
REQ-022 Under i_rst, the following SHALL be cleared to 0: cache_control, all masks, the FIFO pointers, count and overflow, o_copro_read_data, o_cache_flush_req and o_copro_busy; the FSM returns to IDLE.
REQ-023 Reset during FLUSH SHALL abort the flush; a later ack is ignored.
REQ-024 FIFO payload storage SHALL need no reset.

Structure
REQ-025 Package a25_copro15_pkg SHALL hold the CRn index constants (0-7), the operation codes (MRC = 2'd1, MCR = 2'd2) and the flush FSM state encoding.
REQ-026 Sub-module a25_copro15_fault_fifo SHALL implement the parametrised FIFO with push, pop, head, count and full outputs; overflow is held in the parent.
REQ-027 Expected size: 150-300 lines of RTL.

Verification
REQ-028 Reset, then MRC CRn 0 -> next cycle read data 0x41560300; all masks 0; busy 0.
REQ-029 MCR CRn 3 with 0xFFFF_0001, AREA_BITS = 16 -> o_cacheable_area = 0x0001; MRC CRn 3 reads 0x0000_0001.
REQ-030 MCR CRn 1 -> next cycle flush_req and busy = 1; second MCR CRn 1 during FLUSH is ignored; ack after 5 cycles -> next cycle both 0; exactly one flush.
REQ-031 With FAULT_DEPTH = 4, push 5 faults (addresses 0x100-0x500) -> CRn 6 reads 0x8004_00xx; popping via four CRn 7 reads returns 0x100, 0x200, 0x300, 0x400; then o_fault_pending = 0.
REQ-032 With the FIFO full, push and pop in the same cycle -> count stays 4 and overflow is not set; then MCR CRn 6 -> overflow 0.
REQ-033 i_core_stall held high during an MCR CRn 2, a fault and an MRC CRn 7 -> no state change; read data holds its value.
